pipe_beat_packer: RTL and testbench
===================================

Name: pipe_beat_packer

Overview:
- Downstream neighbour of the MiddlePipe register-slice chain. It consumes the narrow DW-bit valid/ready stream at the chain's output.
- Packs RATIO consecutive beats into one DW*RATIO-bit word and presents it on a valid/ready output to the wide consumer.
- Supports early termination of a packet via DataInLast. Partial words are zero-filled and tagged with a beat count.

Parameters:
- DW, 2, width of one input beat in bits.
- RATIO, 4, beats per packed output word (legal range 2..16).
- CW, $clog2(RATIO+1), width of DataOutCnt (derived; do not override).

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Rst  input  1  asynchronous reset, active-high.
- Clear  input  1  synchronous flush, active-high.
- DataIn  input  DW  input beat.
- DataInVld  input  1  input beat valid.
- DataInLast  input  1  beat is the last of its packet; qualified by DataInVld.
- DataInRdy  output  1  packer can accept the beat this cycle.
- DataOut  output  DW*RATIO  packed word; beat 0 in LSBs.
- DataOutCnt  output  CW  number of valid beats in DataOut (1..RATIO).
- DataOutLast  output  1  word closes a packet.
- DataOutVld  output  1  DataOut/DataOutCnt/DataOutLast valid.
- DataOutRdy  input  1  consumer accepts the word this cycle.

Behaviour:
- Internal state:
  - Acc: accumulation register, DW*RATIO bits.
  - Cnt: fill index, 0..RATIO-1.
  - Output register holding DataOut, DataOutCnt, DataOutLast and DataOutVld.
- Reset (Rst=1, asynchronous): Acc=0, Cnt=0, DataOut=0, DataOutCnt=0, DataOutLast=0, DataOutVld=0.
- DataInRdy is combinational: DataInRdy = !Clear && (!DataOutVld || DataOutRdy || (Cnt<RATIO-1 && !DataInLast)).
  - A beat that does not complete a word is always accepted, even while the output is stalled.
- Accept = DataInVld && DataInRdy. On accept, DataIn is written into Acc slice [Cnt*DW +: DW].
- Completion: an accept with Cnt==RATIO-1 or DataInLast=1. On completion, next cycle:
  - DataOut = Acc with the new slice merged and all slices above Cnt zero.
  - DataOutCnt = Cnt+1.
  - DataOutLast = DataInLast.
  - DataOutVld = 1.
  - Cnt = 0 and Acc = 0.
- Non-completing accept: Cnt = Cnt+1; the output register is unchanged.
- Output drain: DataOutVld && DataOutRdy with no completion in the same cycle gives DataOutVld=0 next cycle. DataOut holds its value.
- Simultaneous drain and completion: the output register loads the new word and DataOutVld stays 1. This gives a zero-bubble word-to-word transfer.
- Stall: while DataOutVld && !DataOutRdy, DataOut, DataOutCnt and DataOutLast are stable. A completing beat is refused (DataInRdy=0) until the drain.
- Latency: one cycle from the completing input beat to DataOutVld.
- Throughput: one input beat per cycle sustained when DataOutRdy=1.
- DataOutVld never depends combinationally on DataOutRdy.
- Clear=1 (synchronous, below Rst in priority):
  - Next cycle: Acc=0, Cnt=0, DataOutVld=0, DataOutLast=0.
  - Any held word and any partial word are discarded; DataOut value is don't-care.
  - DataInRdy=0 during the Clear cycle.
- DataInLast with DataInVld=0 is ignored.
- A Last beat at Cnt=0 produces a one-beat word with DataOutCnt=1.
- Reset asserted mid-packet: all state is lost immediately; no partial word is emitted after release.

Test Plan:
- DW=2, RATIO=4, DataOutRdy=1; beats 1,2,3,0 on consecutive cycles, Last=0 -> one cycle after beat 4: DataOutVld=1, DataOut=0x39, DataOutCnt=4, DataOutLast=0, for one cycle.
- Beats 3,1 with Last on the second -> DataOut=0x07, DataOutCnt=2, DataOutLast=1; next packet starts at slice 0.
- DataOutRdy=0 with a word held -> 3 further beats accepted; the 4th sees DataInRdy=0 and the held DataOut is unchanged. Raise DataOutRdy -> held word drains, 4th beat accepted the same cycle, new word valid next cycle.
- 16 back-to-back beats 0..3 repeating with DataOutRdy=1 -> DataInRdy stays 1 and four words of 0xE4 appear, one every 4 cycles.
- Clear asserted after 2 beats -> DataInRdy=0 that cycle and DataOutVld stays 0. The next 4 beats 1,1,1,1 -> DataOut=0x55, Cnt=4 (no stale data).
- Rst pulsed asynchronously mid-cycle with a word held and Cnt=2 -> all outputs 0 immediately. After release, beats 2,2,2,2 -> DataOut=0xAA.

Source files
------------

// File: rtl/pipe_beat_packer.sv
// Packs RATIO consecutive DW-bit stream beats into one wide word on a valid/ready
// output; DataInLast closes a packet early with a zero-filled, beat-counted word.
module pipe_beat_packer #(
  parameter int unsigned DW    = 2,
  parameter int unsigned RATIO = 4,
  parameter int unsigned CW    = $clog2(RATIO + 1)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Clear,
  input  logic [DW-1:0]       DataIn,
  input  logic                DataInVld,
  input  logic                DataInLast,
  output logic                DataInRdy,
  output logic [DW*RATIO-1:0] DataOut,
  output logic [CW-1:0]       DataOutCnt,
  output logic                DataOutLast,
  output logic                DataOutVld,
  input  logic                DataOutRdy
);

  localparam int unsigned WW = DW * RATIO;
  localparam int unsigned NW = $clog2(RATIO);
  localparam logic [NW-1:0] LAST_SLOT = NW'(RATIO - 1);

  logic [WW-1:0] r_acc;
  logic [NW-1:0] r_cnt;
  logic [WW-1:0] r_data_out;
  logic [CW-1:0] r_data_out_cnt;
  logic          r_data_out_last;
  logic          r_data_out_vld;

  logic          w_last_slot;
  logic          w_in_rdy;
  logic          w_accept;
  logic          w_complete;
  logic          w_drain;
  logic [WW-1:0] w_merged;

  // A beat that only extends the partial word never needs the output register.
  assign w_last_slot = (r_cnt == LAST_SLOT);
  assign w_in_rdy    = !Clear && (!r_data_out_vld || DataOutRdy ||
                                  (!w_last_slot && !DataInLast));
  assign w_accept    = DataInVld && w_in_rdy;
  assign w_complete  = w_accept && (w_last_slot || DataInLast);
  assign w_drain     = r_data_out_vld && DataOutRdy;

  // Slices above r_cnt are always zero in r_acc, so the merge is also the zero-filled word.
  always_comb begin
    w_merged = r_acc;
    w_merged[int'(r_cnt)*DW +: DW] = DataIn;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_acc           <= '0;
      r_cnt           <= '0;
      r_data_out      <= '0;
      r_data_out_cnt  <= '0;
      r_data_out_last <= 1'b0;
      r_data_out_vld  <= 1'b0;
    end else if (Clear) begin
      r_acc           <= '0;
      r_cnt           <= '0;
      r_data_out_last <= 1'b0;
      r_data_out_vld  <= 1'b0;
    end else begin
      if (w_complete) begin
        r_data_out      <= w_merged;
        r_data_out_cnt  <= CW'(r_cnt) + CW'(1);
        r_data_out_last <= DataInLast;
        r_data_out_vld  <= 1'b1;
        r_acc           <= '0;
        r_cnt           <= '0;
      end else begin
        if (w_accept) begin
          r_acc <= w_merged;
          r_cnt <= r_cnt + NW'(1);
        end
        if (w_drain) begin
          r_data_out_vld <= 1'b0;
        end
      end
    end
  end

  assign DataInRdy   = w_in_rdy;
  assign DataOut     = r_data_out;
  assign DataOutCnt  = r_data_out_cnt;
  assign DataOutLast = r_data_out_last;
  assign DataOutVld  = r_data_out_vld;

endmodule

// File: tb/tb_pipe_beat_packer.sv
// Bench for pipe_beat_packer: directed scenarios with fixed expected words, then a
// randomized run against a packet-level queue model of the packer.
module tb_pipe_beat_packer;

  localparam int unsigned DW    = 2;
  localparam int unsigned RATIO = 4;
  localparam int unsigned CW    = $clog2(RATIO + 1);
  localparam int unsigned WW    = DW * RATIO;

  logic          Clk;
  logic          Rst;
  logic          Clear;
  logic [DW-1:0] DataIn;
  logic          DataInVld;
  logic          DataInLast;
  logic          DataInRdy;
  logic [WW-1:0] DataOut;
  logic [CW-1:0] DataOutCnt;
  logic          DataOutLast;
  logic          DataOutVld;
  logic          DataOutRdy;

  int checks   = 0;
  int failures = 0;

  pipe_beat_packer #(.DW(DW), .RATIO(RATIO)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Clear      (Clear),
    .DataIn     (DataIn),
    .DataInVld  (DataInVld),
    .DataInLast (DataInLast),
    .DataInRdy  (DataInRdy),
    .DataOut    (DataOut),
    .DataOutCnt (DataOutCnt),
    .DataOutLast(DataOutLast),
    .DataOutVld (DataOutVld),
    .DataOutRdy (DataOutRdy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l);
    DataInVld  = 1'b1;
    DataIn     = d;
    DataInLast = l;
  endtask

  task automatic idle();
    DataInVld  = 1'b0;
    DataIn     = '0;
    DataInLast = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Clear = 1'b0; DataOutRdy = 1'b0; idle();
    #3;
    checks += 4;
    if (DataOutVld !== 1'b0) begin failures++; $display("FAIL reset_vld got %b exp 0", DataOutVld); end
    if (DataOut !== 8'h00) begin failures++; $display("FAIL reset_data got %h exp 00", DataOut); end
    if (DataOutCnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got %0d exp 0", DataOutCnt); end
    if (DataOutLast !== 1'b0) begin failures++; $display("FAIL reset_last got %b exp 0", DataOutLast); end
    @(negedge Clk);
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_full_word();
    logic [DW-1:0] b [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    DataOutRdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(b[i], 1'b0);
      tick();
      if (i < 3) begin
        checks++;
        if (DataOutVld !== 1'b0) begin failures++; $display("FAIL full_early_vld beat %0d got %b exp 0", i, DataOutVld); end
      end
    end
    checks += 4;
    if (DataOutVld !== 1'b1) begin failures++; $display("FAIL full_vld got %b exp 1", DataOutVld); end
    if (DataOut !== 8'h39) begin failures++; $display("FAIL full_data got %h exp 39", DataOut); end
    if (DataOutCnt !== 3'd4) begin failures++; $display("FAIL full_cnt got %0d exp 4", DataOutCnt); end
    if (DataOutLast !== 1'b0) begin failures++; $display("FAIL full_last got %b exp 0", DataOutLast); end
    idle();
    tick();
    checks++;
    if (DataOutVld !== 1'b0) begin failures++; $display("FAIL full_drain_vld got %b exp 0", DataOutVld); end
  endtask

  task automatic test_last();
    DataOutRdy = 1'b1;
    beat(2'd3, 1'b0); tick();
    beat(2'd1, 1'b1); tick();
    checks += 4;
    if (DataOutVld !== 1'b1) begin failures++; $display("FAIL last_vld got %b exp 1", DataOutVld); end
    if (DataOut !== 8'h07) begin failures++; $display("FAIL last_data got %h exp 07", DataOut); end
    if (DataOutCnt !== 3'd2) begin failures++; $display("FAIL last_cnt got %0d exp 2", DataOutCnt); end
    if (DataOutLast !== 1'b1) begin failures++; $display("FAIL last_last got %b exp 1", DataOutLast); end
    beat(2'd2, 1'b1); tick();
    checks += 3;
    if (DataOut !== 8'h02) begin failures++; $display("FAIL last1_data got %h exp 02", DataOut); end
    if (DataOutCnt !== 3'd1) begin failures++; $display("FAIL last1_cnt got %0d exp 1", DataOutCnt); end
    if (DataOutVld !== 1'b1) begin failures++; $display("FAIL last1_vld got %b exp 1", DataOutVld); end
    idle(); tick();
  endtask

  task automatic test_stall();
    logic [DW-1:0] b [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    DataOutRdy = 1'b0;
    for (int i = 0; i < 4; i++) begin beat(b[i], 1'b0); tick(); end
    for (int i = 0; i < 3; i++) begin
      beat(2'd1, 1'b0);
      #1;
      checks++;
      if (DataInRdy !== 1'b1) begin failures++; $display("FAIL stall_accept beat %0d got %b exp 1", i, DataInRdy); end
      tick();
    end
    beat(2'd2, 1'b0);
    #1;
    checks++;
    if (DataInRdy !== 1'b0) begin failures++; $display("FAIL stall_refuse got %b exp 0", DataInRdy); end
    tick();
    checks += 3;
    if (DataOutVld !== 1'b1) begin failures++; $display("FAIL stall_hold_vld got %b exp 1", DataOutVld); end
    if (DataOut !== 8'h39) begin failures++; $display("FAIL stall_hold_data got %h exp 39", DataOut); end
    if (DataInRdy !== 1'b0) begin failures++; $display("FAIL stall_refuse2 got %b exp 0", DataInRdy); end
    DataOutRdy = 1'b1;
    #1;
    checks++;
    if (DataInRdy !== 1'b1) begin failures++; $display("FAIL stall_release_rdy got %b exp 1", DataInRdy); end
    tick();
    checks += 3;
    if (DataOutVld !== 1'b1) begin failures++; $display("FAIL stall_next_vld got %b exp 1", DataOutVld); end
    if (DataOut !== 8'h95) begin failures++; $display("FAIL stall_next_data got %h exp 95", DataOut); end
    if (DataOutCnt !== 3'd4) begin failures++; $display("FAIL stall_next_cnt got %0d exp 4", DataOutCnt); end
    idle(); tick();
    checks++;
    if (DataOutVld !== 1'b0) begin failures++; $display("FAIL stall_drain_vld got %b exp 0", DataOutVld); end
  endtask

  task automatic test_back_to_back();
    int words = 0;
    DataOutRdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      beat(DW'(i % 4), 1'b0);
      #1;
      checks++;
      if (DataInRdy !== 1'b1) begin failures++; $display("FAIL b2b_rdy beat %0d got %b exp 1", i, DataInRdy); end
      tick();
      checks++;
      if (DataOutVld !== ((i % 4) == 3)) begin failures++; $display("FAIL b2b_vld beat %0d got %b exp %b", i, DataOutVld, ((i % 4) == 3)); end
      if (DataOutVld === 1'b1 && DataOut === 8'hE4) words++;
    end
    checks++;
    if (words != 4) begin failures++; $display("FAIL b2b_words got %0d exp 4", words); end
    idle(); tick();
  endtask

  task automatic test_clear();
    DataOutRdy = 1'b1;
    beat(2'd3, 1'b0); tick();
    beat(2'd3, 1'b0); tick();
    beat(2'd3, 1'b0);
    Clear = 1'b1;
    #1;
    checks++;
    if (DataInRdy !== 1'b0) begin failures++; $display("FAIL clear_rdy got %b exp 0", DataInRdy); end
    tick();
    Clear = 1'b0;
    checks++;
    if (DataOutVld !== 1'b0) begin failures++; $display("FAIL clear_vld got %b exp 0", DataOutVld); end
    for (int i = 0; i < 4; i++) begin beat(2'd1, 1'b0); tick(); end
    checks += 3;
    if (DataOutVld !== 1'b1) begin failures++; $display("FAIL clear_post_vld got %b exp 1", DataOutVld); end
    if (DataOut !== 8'h55) begin failures++; $display("FAIL clear_post_data got %h exp 55", DataOut); end
    if (DataOutCnt !== 3'd4) begin failures++; $display("FAIL clear_post_cnt got %0d exp 4", DataOutCnt); end
    idle(); tick();
  endtask

  task automatic test_async_reset();
    DataOutRdy = 1'b0;
    beat(2'd3, 1'b1); tick();
    beat(2'd1, 1'b0); tick();
    beat(2'd2, 1'b0); tick();
    idle();
    #2;
    Rst = 1'b1;
    #1;
    checks += 4;
    if (DataOutVld !== 1'b0) begin failures++; $display("FAIL arst_vld got %b exp 0", DataOutVld); end
    if (DataOut !== 8'h00) begin failures++; $display("FAIL arst_data got %h exp 00", DataOut); end
    if (DataOutCnt !== 3'd0) begin failures++; $display("FAIL arst_cnt got %0d exp 0", DataOutCnt); end
    if (DataOutLast !== 1'b0) begin failures++; $display("FAIL arst_last got %b exp 0", DataOutLast); end
    #1;
    Rst = 1'b0;
    tick();
    DataOutRdy = 1'b1;
    for (int i = 0; i < 4; i++) begin beat(2'd2, 1'b0); tick(); end
    checks += 4;
    if (DataOutVld !== 1'b1) begin failures++; $display("FAIL arst_post_vld got %b exp 1", DataOutVld); end
    if (DataOut !== 8'hAA) begin failures++; $display("FAIL arst_post_data got %h exp AA", DataOut); end
    if (DataOutCnt !== 3'd4) begin failures++; $display("FAIL arst_post_cnt got %0d exp 4", DataOutCnt); end
    if (DataOutLast !== 1'b0) begin failures++; $display("FAIL arst_post_last got %b exp 0", DataOutLast); end
    idle(); tick();
  endtask

  // Model: beats of the open word in a queue, plus at most one pending output word.
  task automatic test_random();
    logic [DW-1:0] part[$];
    logic          m_pend = 1'b0;
    logic [WW-1:0] m_word = '0;
    int            m_cnt  = 0;
    logic          m_last = 1'b0;
    logic          exp_rdy;
    logic          acc;
    logic          comp;
    for (int c = 0; c < 800; c++) begin
      DataInVld  = ($urandom_range(0, 3) != 0);
      DataIn     = DW'($urandom);
      DataInLast = ($urandom_range(0, 5) == 0);
      DataOutRdy = ($urandom_range(0, 2) != 0);
      Clear      = ($urandom_range(0, 39) == 0);
      #1;
      exp_rdy = !Clear && (!m_pend || DataOutRdy ||
                           (part.size() < RATIO - 1 && !DataInLast));
      checks += 2;
      if (DataInRdy !== exp_rdy) begin failures++; $display("FAIL rnd_rdy cycle %0d got %b exp %b", c, DataInRdy, exp_rdy); end
      if (DataOutVld !== m_pend) begin failures++; $display("FAIL rnd_vld cycle %0d got %b exp %b", c, DataOutVld, m_pend); end
      if (m_pend) begin
        checks += 3;
        if (DataOut !== m_word) begin failures++; $display("FAIL rnd_data cycle %0d got %h exp %h", c, DataOut, m_word); end
        if (DataOutCnt !== CW'(m_cnt)) begin failures++; $display("FAIL rnd_cnt cycle %0d got %0d exp %0d", c, DataOutCnt, m_cnt); end
        if (DataOutLast !== m_last) begin failures++; $display("FAIL rnd_last cycle %0d got %b exp %b", c, DataOutLast, m_last); end
      end
      if (Clear) begin
        part.delete();
        m_pend = 1'b0;
      end else begin
        acc  = DataInVld && exp_rdy;
        comp = 1'b0;
        if (acc) begin
          part.push_back(DataIn);
          if (part.size() == RATIO || DataInLast) comp = 1'b1;
        end
        if (comp) begin
          m_word = '0;
          foreach (part[i]) m_word = m_word | (WW'(part[i]) << (i * DW));
          m_cnt  = part.size();
          m_last = DataInLast;
          m_pend = 1'b1;
          part.delete();
        end else if (m_pend && DataOutRdy) begin
          m_pend = 1'b0;
        end
      end
      tick();
    end
    Clear = 1'b0;
    DataOutRdy = 1'b1;
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_last();
    test_stall();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
